// File: rtl/switch_input_port_if.sv
// CPU-side bus of the switch input port: read strobe plus held word and status.
// The port drives the slave side; the CPU (or bench) drives the master side.
interface switch_input_port_if;
    logic        rd_en;
    logic [31:0] data_out;
    logic        data_valid;
    logic        overrun;

    // Handshake: data_valid is high while a captured value is waiting.
    // A one-cycle rd_en while data_valid=1 consumes it at that clock edge.
    // rd_en while data_valid=0 is ignored.
    modport master (
        output rd_en,
        input  data_out,
        input  data_valid,
        input  overrun
    );

    modport slave (
        input  rd_en,
        output data_out,
        output data_valid,
        output overrun
    );
endinterface

// File: rtl/switch_input_port.sv
// Debounced switch/button input port: a debounced button press latches the
// synchronized switches into a CPU-readable holding register.
module switch_input_port #(
    parameter int SW_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] sw,
    input  logic                btn,
    output logic                btn_level,
    switch_input_port_if.slave  cpu
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sw_meta_q, sw_s_q;
    logic                btn_meta_q, btn_s_q;
    logic                btn_db_q, btn_db_d;
    logic                btn_db_prev_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SW_WIDTH-1:0] value_q, value_d;
    logic [7:0]          press_cnt_q, press_cnt_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                press;
    logic [15:0]         value_ext;

    // Debouncer: the synchronized level must differ from the accepted level
    // for DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
    always_comb begin
        btn_db_d = btn_db_q;
        cnt_d    = cnt_q;
        if (btn_s_q == btn_db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            btn_db_d = btn_s_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign press = btn_db_q & ~btn_db_prev_q;

    // A press always wins over a coinciding read; the read then only clears overrun.
    always_comb begin
        value_d     = value_q;
        press_cnt_d = press_cnt_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        if (press) begin
            value_d     = sw_s_q;
            press_cnt_d = press_cnt_q + 8'd1;
            valid_d     = 1'b1;
            if (valid_q && !cpu.rd_en) begin
                overrun_d = 1'b1;
            end else if (valid_q && cpu.rd_en) begin
                overrun_d = 1'b0;
            end
        end else if (cpu.rd_en && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q     <= '0;
            sw_s_q        <= '0;
            btn_meta_q    <= 1'b0;
            btn_s_q       <= 1'b0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            cnt_q         <= '0;
            value_q       <= '0;
            press_cnt_q   <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sw_meta_q     <= sw;
            sw_s_q        <= sw_meta_q;
            btn_meta_q    <= btn;
            btn_s_q       <= btn_meta_q;
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_q;
            cnt_q         <= cnt_d;
            value_q       <= value_d;
            press_cnt_q   <= press_cnt_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
        end
    end

    // Zero-extend through a 16-bit field so SW_WIDTH=16 needs no empty replication.
    assign value_ext      = 16'(value_q);
    assign cpu.data_out   = {overrun_q, 7'b0, press_cnt_q, value_ext};
    assign cpu.data_valid = valid_q;
    assign cpu.overrun    = overrun_q;
    assign btn_level      = btn_db_q;

endmodule

// File: doc/switch_input_port.md
# switch_input_port

Debounced, CPU-readable switch/button input port. It is the input-side counterpart of the seven-segment register display. Board switches hold a value, and a press of the load button latches that value into a 32-bit holding register with a valid flag and an overrun flag. The CPU consumes the value through a single-cycle read strobe. It runs in the same divided clock domain as the CPU.

## Interface
Parameters:
- SW_WIDTH, 8: number of data switches; legal range 1..16.
- DEBOUNCE_CYCLES, 500: consecutive stable synchronized samples required to accept a button level change; minimum 2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- sw  in  SW_WIDTH  raw asynchronous switch inputs.
- btn  in  1  raw asynchronous load button; active-high, bouncy.
- rd_en  in  1  CPU read strobe; one-cycle pulse consumes the held value.
- data_out  out  32  {overrun, 7'b0, press_count[7:0], (16-SW_WIDTH)'b0, value[SW_WIDTH-1:0]}.
- data_valid  out  1  held value captured and not yet read.
- overrun  out  1  sticky; a capture occurred while data_valid=1 with no read that cycle.
- btn_level  out  1  debounced button level, for LED feedback.

## Operation
- Synchronizer: sw and btn each pass through two flops (sw_s, btn_s). Reset value is 0.
- Debouncer: counter cnt, width clog2(DEBOUNCE_CYCLES).
  - If btn_s == btn_db, cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: btn_db <= btn_s and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any return to the old level before acceptance restarts the count from 0.
- Edge detect: btn_db_q <= btn_db. A press is btn_db & ~btn_db_q. Releases generate no event.
- Press handling, registered next edge:
  - value <= sw_s.
  - press_count <= press_count+1, 8-bit, wraps 255 -> 0.
  - data_valid <= 1.
  - If data_valid=1 and rd_en=0 in that cycle, overrun <= 1.
- Read with no press: rd_en=1 and data_valid=1 give data_valid <= 0 and overrun <= 0. value and press_count are retained.
- Read with data_valid=0: ignored, no state change.
- Simultaneous press and rd_en, with data_valid=1: the new capture wins. data_valid stays 1, overrun <= 0, and the old value is considered consumed.
- data_out is combinational from registered state (value, press_count, overrun). No further latency.
- btn_level = btn_db.
- Reset values: all flops 0. That covers data_out=0, data_valid=0, overrun=0, btn_level=0, and cnt=0.
- Reset mid-debounce or mid-capture discards everything. A button still held after reset release must be re-debounced and then produces exactly one press.

## Timing
- Let btn rise cleanly before edge 0.
  - btn_s=1 after edge 2.
  - btn_db=1 after edge 2+DEBOUNCE_CYCLES.
  - data_valid=1 after edge 3+DEBOUNCE_CYCLES.
  - Press-to-valid latency is DEBOUNCE_CYCLES+3 cycles.
- Captured value is sw_s at the capture edge. sw must be stable for at least 3 cycles before that edge.
- Pulses or bounce intervals shorter than DEBOUNCE_CYCLES synchronized cycles are rejected.
- rd_en takes effect at the edge it is sampled on. data_valid falls 1 cycle after the rd_en pulse.
- Maximum press rate is one per 2*DEBOUNCE_CYCLES cycles, because a release must also debounce.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and SW_WIDTH=8.
- Reset: assert rst for 2 cycles with btn=1, sw=8'hFF -> data_out=0, data_valid=0, overrun=0, btn_level=0. After release, exactly one press is seen at cycle 7 post-reset.
- Clean press: sw=8'hA5, btn rises at edge 0 -> btn_level=1 after edge 6, data_valid=1 after edge 7, data_out=32'h0001_00A5. rd_en pulse -> data_valid=0 on the next cycle, data_out unchanged.
- Bounce: btn toggles 1,0,1,1,0 one cycle each, then holds 1 -> single press, press_count=1. A 3-cycle pulse alone -> no press.
- Overrun: two debounced presses (sw=8'h11 then 8'h22) with no read -> data_out=32'h8002_0022, data_valid=1. rd_en -> overrun=0, data_valid=0.
- Simultaneous events: rd_en coincides with the capture edge of the 2nd press while data_valid=1 -> data_valid stays 1, overrun=0, value=new sw.
- Counter wrap: 256 presses -> press_count returns to 0x00. rd_en with data_valid=0 -> no state change.
